popcount_feeder: RTL and testbench

POPCOUNT_FEEDER -- requirements
Module: popcount_feeder

---
 rtl/popcount_feeder_pkg.sv | 23 ++
 rtl/popcount_feeder_if.sv | 36 +++
 rtl/popcount_feeder_word_fifo.sv | 66 ++++++
 rtl/popcount_feeder.sv | 126 ++++++++++++
 tb/tb_popcount_feeder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_feeder_pkg.sv
// ---------------------------------------------------------------------------
// popcount_feeder_pkg : shared widths, parameter defaults and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package popcount_feeder_pkg;

  localparam int DEPTH_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 24;
  localparam int WORD_W          = 16;
  localparam int COUNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/popcount_feeder_if.sv
// ---------------------------------------------------------------------------
// popcount_feeder_if : upstream stream, counter hookup and result channel
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface popcount_feeder_if;
  import popcount_feeder_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [WORD_W-1:0]  s_data;
  logic               cnt_reset;
  logic [WORD_W-1:0]  cnt_word;
  logic [COUNT_W-1:0] cnt_no_ones;
  logic               cnt_end_flag;
  logic               m_valid;
  logic               m_ready;
  logic [COUNT_W-1:0] m_count;
  logic               m_all_ones;
  logic               m_timeout;

  // Environment side: producer, external counter and result consumer
  modport master (
    output s_valid, s_data, cnt_no_ones, cnt_end_flag, m_ready,
    input  s_ready, cnt_reset, cnt_word, m_valid, m_count, m_all_ones, m_timeout
  );

  modport slave (
    input  s_valid, s_data, cnt_no_ones, cnt_end_flag, m_ready,
    output s_ready, cnt_reset, cnt_word, m_valid, m_count, m_all_ones, m_timeout
  );

endinterface

`default_nettype wire

// File: rtl/popcount_feeder_word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo : power-of-two synchronous FIFO with wrap-bit full/empty detect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define valid contents
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/popcount_feeder.sv
// ---------------------------------------------------------------------------
// popcount_feeder : buffers words and sequences an external bit-serial counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module popcount_feeder
  import popcount_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input wire logic        clk,
  input wire logic        reset,
  popcount_feeder_if.slave bus
);

  localparam int             TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               clear_phase_q, clear_phase_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [WORD_W-1:0]  cnt_word_q, cnt_word_d;
  logic [COUNT_W-1:0] m_count_q, m_count_d;
  logic               m_all_ones_q, m_all_ones_d;
  logic               m_timeout_q, m_timeout_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [WORD_W-1:0]  fifo_rdata;
  logic               ready;
  logic               push;
  logic               pop;
  logic               run_timeout;

  assign ready       = !fifo_full && !reset;
  assign push        = bus.s_valid && ready;
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;
  assign run_timeout = !bus.cnt_end_flag && (timer_q == TIMER_LAST);

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      clear_phase_q <= 1'b0;
      timer_q       <= '0;
      cnt_word_q    <= '0;
      m_count_q     <= '0;
      m_all_ones_q  <= 1'b0;
      m_timeout_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_phase_q <= clear_phase_d;
      timer_q       <= timer_d;
      cnt_word_q    <= cnt_word_d;
      m_count_q     <= m_count_d;
      m_all_ones_q  <= m_all_ones_d;
      m_timeout_q   <= m_timeout_d;
    end
  end

  // Timer is zero on every RUN entry because it is cleared whenever RUN is not held
  always_comb begin
    state_d       = state_q;
    clear_phase_d = 1'b0;
    timer_d       = '0;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_CLEAR;
      ST_CLEAR: begin
        clear_phase_d = !clear_phase_q;
        if (clear_phase_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.cnt_end_flag || run_timeout) state_d = ST_DONE;
        else                                 timer_d = timer_q + 1'b1;
      end
      ST_DONE:  if (bus.m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_word_d   = pop ? fifo_rdata : cnt_word_q;
    m_count_d    = m_count_q;
    m_all_ones_d = m_all_ones_q;
    m_timeout_d  = m_timeout_q;
    if (state_q == ST_RUN) begin
      if (bus.cnt_end_flag) begin
        m_count_d    = bus.cnt_no_ones;
        m_all_ones_d = (cnt_word_q == 16'hFFFF);
        m_timeout_d  = 1'b0;
      end else if (run_timeout) begin
        m_count_d    = '0;
        m_all_ones_d = 1'b0;
        m_timeout_d  = 1'b1;
      end
    end
  end

  always_comb begin
    bus.s_ready    = ready;
    bus.cnt_reset  = (state_q != ST_RUN);
    bus.cnt_word   = cnt_word_q;
    bus.m_valid    = (state_q == ST_DONE);
    bus.m_count    = m_count_q;
    bus.m_all_ones = m_all_ones_q;
    bus.m_timeout  = m_timeout_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_popcount_feeder.sv
// ---------------------------------------------------------------------------
// tb_popcount_feeder : vector table, scoreboard and bit-serial counter model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_popcount_feeder;

  localparam int TIMEOUT = 24;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [15:0] data;
    int          cnt;
    logic        all1;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic       all1;
    logic       tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   tie_zero = 1'b0;
  logic [4:0] idx_q;
  logic [4:0] acc_q;
  exp_t sb[$];

  popcount_feeder_if bus();

  popcount_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit-serial ones counter: one bit per cycle, flag once all 16 bits are summed
  always_ff @(posedge clk) begin
    if (bus.cnt_reset) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (idx_q < 5'd16) begin
      acc_q <= acc_q + {4'd0, bus.cnt_word[idx_q[3:0]]};
      idx_q <= idx_q + 5'd1;
    end
  end
  assign bus.cnt_no_ones  = acc_q[3:0];
  assign bus.cnt_end_flag = !tie_zero && (idx_q == 5'd16);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input bit tmo);
    exp_t e;
    int   n = 0;
    for (int i = 0; i < 16; i++) n += int'(d[i]);
    e.cnt  = tmo ? 4'd0 : 4'(n);
    e.all1 = tmo ? 1'b0 : (d == 16'hFFFF);
    e.tmo  = tmo;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.s_valid && bus.s_ready) sb.push_back(model(bus.s_data, tie_zero));
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got result count %0d with nothing outstanding", bus.m_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_count",    32'(bus.m_count),    32'(e.cnt));
          chk("sb_all_ones", 32'(bus.m_all_ones), 32'(e.all1));
          chk("sb_timeout",  32'(bus.m_timeout),  32'(e.tmo));
        end
      end
    end
  end

  // Callers enter at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic push_word(input logic [15:0] d);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    do begin @(negedge clk); n++; end while (!bus.s_ready && n < 100);
    chk("push_accepted", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m_valid && n < 200);
    chk("valid_seen", 32'(bus.m_valid), 32'd1);
  endtask

  task automatic wait_run();
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.cnt_reset && n < 100);
    chk("run_entered", 32'(bus.cnt_reset), 32'd0);
  endtask

  vec_t        vecs[5];
  logic [15:0] bp_data[5];
  int          bp_cnt[5];

  initial begin
    int n;
    int vcount;
    int run_low;
    logic [3:0]  hold_cnt;
    logic [15:0] hold_word;

    vecs[0] = '{16'h00F0, 4, 1'b0};
    vecs[1] = '{16'hFFFF, 0, 1'b1};
    vecs[2] = '{16'h0000, 0, 1'b0};
    vecs[3] = '{16'hA5C3, 8, 1'b0};
    vecs[4] = '{16'h8000, 1, 1'b0};
    bp_data = '{16'h0101, 16'h0001, 16'h0003, 16'h8001, 16'h7FFF};
    bp_cnt  = '{2, 1, 2, 2, 15};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_s_ready",    32'(bus.s_ready),    32'd0);
    chk("rst_cnt_reset",  32'(bus.cnt_reset),  32'd1);
    chk("rst_cnt_word",   32'(bus.cnt_word),   32'd0);
    chk("rst_m_valid",    32'(bus.m_valid),    32'd0);
    chk("rst_m_count",    32'(bus.m_count),    32'd0);
    chk("rst_m_all_ones", 32'(bus.m_all_ones), 32'd0);
    chk("rst_m_timeout",  32'(bus.m_timeout),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

    // Single words at an idle block: 1 + 1 + 2 + 17 edges to m_valid
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_word(vecs[i].data);
      wait_valid(n);
      chk("vec_latency",  32'(n),              32'd21);
      chk("vec_count",    32'(bus.m_count),    32'(vecs[i].cnt));
      chk("vec_all_ones", 32'(bus.m_all_ones), 32'(vecs[i].all1));
      chk("vec_timeout",  32'(bus.m_timeout),  32'd0);
      chk("vec_cnt_word", 32'(bus.cnt_word),   32'(vecs[i].data));
      @(negedge clk);
      chk("vec_valid_drop", 32'(bus.m_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Back-to-back burst with the sink stalled: one word in flight, four buffered
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = bp_data[i];
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.s_ready && n < 50);
      chk("bp_accept", 32'(bus.s_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.s_data = 16'hAAAA;
    @(negedge clk);
    chk("bp_full_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    wait_valid(n);
    hold_cnt  = bus.m_count;
    hold_word = bus.cnt_word;
    repeat (5) @(negedge clk);
    chk("hold_valid",    32'(bus.m_valid),  32'd1);
    chk("hold_count",    32'(bus.m_count),  32'(hold_cnt));
    chk("hold_cnt_word", 32'(bus.cnt_word), 32'(hold_word));
    chk("hold_s_ready",  32'(bus.s_ready),  32'd0);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      chk("bp_order_count", 32'(bus.m_count), 32'(bp_cnt[i]));
      chk("bp_order_word",  32'(bus.cnt_word), 32'(bp_data[i]));
      @(negedge clk);
    end

    // Counter that never finishes
    @(posedge clk); #1;
    tie_zero = 1'b1;
    push_word(16'h1234);
    wait_run();
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m_valid && n < 100);
    chk("tmo_cycles",   32'(n),              32'(TIMEOUT));
    chk("tmo_flag",     32'(bus.m_timeout),  32'd1);
    chk("tmo_count",    32'(bus.m_count),    32'd0);
    chk("tmo_all_ones", 32'(bus.m_all_ones), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    tie_zero = 1'b0;

    // Reset mid-RUN discards the word and its result
    push_word(16'h00FF);
    wait_run();
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vcount  = 0;
    run_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.m_valid)    vcount++;
      if (!bus.cnt_reset) run_low++;
    end
    chk("rst_run_no_valid", 32'(vcount),        32'd0);
    chk("rst_run_parked",   32'(run_low),       32'd0);
    chk("rst_run_cnt_rst",  32'(bus.cnt_reset), 32'd1);
    chk("rst_run_s_ready",  32'(bus.s_ready),   32'd1);
    @(posedge clk); #1;
    push_word(16'h000F);
    wait_valid(n);
    chk("post_rst_count",    32'(bus.m_count),    32'd4);
    chk("post_rst_all_ones", 32'(bus.m_all_ones), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
